cf_gpio_bank: RTL and testbench
===============================

// Module: cf_gpio_bank
// PURPOSE
//  - Parametrised, runtime-configurable bank of Sky130 Openframe GPIO pad controllers; successor to the fixed-MODE per-pad wrapper.
//  - Holds a 3-bit mode register per pin (same mode encoding: 0 ANALOG, 1 INPUT, 2 INPUT_PD, 3 INPUT_PU, 4 OUTPUT, 5 BIDIR).
//  - A single write port changes modes; every change is sequenced through a hi-Z PARK window so that no pad glitches into drive.
//  - Input paths are synchronised. Sits between user logic and openframe_project_wrapper pad-config buses.
// PARAMETERS
//  NUM_PINS     8     number of pads controlled (1..44)
//  SYNC_STAGES  2     flops per gpio_in synchroniser (>=2)
//  PARK_CYCLES  2     cycles a pin is held parked (dm=001, oeb=1, out=0, inp_dis=0) before a new mode applies (>=1)
//  RESET_MODE   3'd1  mode loaded into every pin on reset (must be 0..5)
// PORTS
//  clk              in   1            bank clock
//  rst              in   1            synchronous, active-high reset
//  cfg_we           in   1            mode write strobe; accepted when cfg_ready=1
//  cfg_idx          in   IW           pin index, IW=$clog2(NUM_PINS) (min 1)
//  cfg_mode         in   3            new mode for pin cfg_idx
//  cfg_ready        out  1            1 = sequencer idle, write may be accepted
//  cfg_err          out  1            1-cycle pulse: write rejected
//  mode_q           out  3*NUM_PINS   current applied mode per pin, pin n at [3n+2:3n]
//  io_out           in   NUM_PINS     user output data
//  io_oeb           in   NUM_PINS     user output-enable-bar (BIDIR only)
//  io_in            out  NUM_PINS     synchronised pad input
//  gpio_in          in   NUM_PINS     raw pad input
//  gpio_dm          out  3*NUM_PINS   drive mode per pin
//  gpio_inp_dis, gpio_oeb, gpio_out   out  NUM_PINS each    pad controls
//  gpio_analog_en, gpio_analog_sel, gpio_analog_pol, gpio_ib_mode_sel,
//  gpio_vtrip_sel, gpio_slow_sel, gpio_holdover   out  NUM_PINS each   tied 0
//  irq              out  1            edge interrupt (CF_GPIO_BANK_IRQ_EN only, else 0)
//  irq_clr          in   NUM_PINS     write-1-to-clear pending edges (ignored without macro)
// BEHAVIOUR
//  - Per-mode pad encoding: ANALOG dm=000 inp_dis=1 oeb=1 out=0; INPUT 001/0/1/0; INPUT_PD 011/0/0/0; INPUT_PU 010/0/0/1;
//    OUTPUT 110/1/0/io_out; BIDIR 110/0/io_oeb/io_out.
//  - All gpio_dm/inp_dis/oeb/out are registered: io_out/io_oeb -> pad has 1-cycle latency.
//  - Reset (clock edge with rst=1): all mode_q=RESET_MODE, pad regs = RESET_MODE encoding, sync flops=0, io_in=0,
//    cfg_ready=1, cfg_err=0, irq=0, pending=0. A reset mid-PARK aborts the sequence; no partial mode is kept.
//  - Sequencer FSM: IDLE -> PARK -> APPLY -> IDLE.
//  - IDLE: cfg_we & valid & cfg_mode!=mode_q[idx] captures idx/mode and goes to PARK. cfg_ready=0 from the next cycle.
//  - A same-mode write is accepted as a no-op: stays IDLE, no park.
//  - PARK: target pin's pad regs hold the park encoding for exactly PARK_CYCLES cycles (cycle counter); other pins unaffected.
//  - APPLY: mode_q[idx] updated; pad regs take the new encoding on the next edge; FSM returns to IDLE, cfg_ready=1.
//  - Write at cycle T: park visible T+1..T+PARK_CYCLES; new mode visible T+PARK_CYCLES+1; cfg_ready=1 at T+PARK_CYCLES+1.
//  - Reject (cfg_err pulses on T+1, state and mode_q unchanged): cfg_mode>5, cfg_idx>=NUM_PINS,
//    or cfg_we while cfg_ready=0 (write dropped, in-flight sequence continues).
//  - io_in = last synchroniser stage; io_in is forced 0 while the pin's applied mode is ANALOG or OUTPUT.
// CONFIGURATION
//  - CF_GPIO_BANK_IRQ_EN defined: per-pin pending bit set on any edge of io_in (previous vs current synced value), pin in
//    INPUT/INPUT_PD/INPUT_PU/BIDIR only.
//    irq = |pending, registered. irq_clr[n]=1 clears bit n; a simultaneous new edge wins (bit stays 1).
//  - Undefined: no pending/edge flops, irq tied 0, irq_clr unused.
// STRUCTURE
//  - Package cf_gpio_pkg: mode localparams MODE_*, dm encodings DM_*, function pad_enc(mode, io_out, io_oeb) returning
//    {dm, inp_dis, oeb, out}, and the park encoding constant.
//  - Sub-module cf_gpio_sync (SYNC_STAGES-deep 1-bit synchroniser, synchronous reset), instantiated NUM_PINS times.
//  - Sequencer FSM and pad registers live in cf_gpio_bank.
// TESTING
//  - Reset with RESET_MODE=1: all gpio_dm=001, oeb=1, inp_dis=0, cfg_ready=1, io_in=0; gpio_in=1 -> io_in=1 after 2 clks.
//  - Write pin3 OUTPUT at T (PARK_CYCLES=2): pin3 oeb=1 at T+1..T+2; dm=110, oeb=0, out follows io_out from T+3; cfg_ready=1 at T+3.
//  - Write cfg_mode=6, cfg_idx=NUM_PINS, and a write during PARK: each gives a 1-cycle cfg_err, mode_q unchanged.
//  - BIDIR pin: io_oeb 0->1 -> gpio_oeb 1 a cycle later. INPUT_PU: dm=010, oeb=0, out=1.
//    ANALOG: inp_dis=1, io_in=0 regardless of gpio_in.
//  - Assert rst mid-PARK: next cycle all pins RESET_MODE encoding, cfg_ready=1, no cfg_err.
//  - IRQ_EN: rising gpio_in on an INPUT pin -> irq=1; irq_clr pulse -> irq=0; clear coincident with a new edge -> irq stays 1.

Source files
------------

// File: rtl/cf_gpio_pkg.sv
// Shared definitions for the Openframe GPIO bank: pin modes, drive-mode codes,
// the pad control struct and the mode-to-pad encoding.
package cf_gpio_pkg;

  localparam logic [2:0] MODE_ANALOG   = 3'd0;
  localparam logic [2:0] MODE_INPUT    = 3'd1;
  localparam logic [2:0] MODE_INPUT_PD = 3'd2;
  localparam logic [2:0] MODE_INPUT_PU = 3'd3;
  localparam logic [2:0] MODE_OUTPUT   = 3'd4;
  localparam logic [2:0] MODE_BIDIR    = 3'd5;

  localparam logic [2:0] DM_ANALOG    = 3'b000;
  localparam logic [2:0] DM_INPUT     = 3'b001;
  localparam logic [2:0] DM_PULL_UP   = 3'b010;
  localparam logic [2:0] DM_PULL_DOWN = 3'b011;
  localparam logic [2:0] DM_STRONG    = 3'b110;

  typedef struct packed {
    logic [2:0] dm;
    logic       inp_dis;
    logic       oeb;
    logic       out;
  } pad_cfg_t;

  // Safe intermediate state: plain input buffer, driver off.
  localparam pad_cfg_t PAD_PARK = '{dm: DM_INPUT, inp_dis: 1'b0, oeb: 1'b1, out: 1'b0};

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_PARK,
    SEQ_APPLY
  } seq_state_t;

  function automatic logic mode_valid(input logic [2:0] mode);
    return mode <= MODE_BIDIR;
  endfunction

  // Modes in which the pad input buffer is meaningful to user logic.
  function automatic logic mode_senses(input logic [2:0] mode);
    return (mode == MODE_INPUT) || (mode == MODE_INPUT_PD) ||
           (mode == MODE_INPUT_PU) || (mode == MODE_BIDIR);
  endfunction

  function automatic pad_cfg_t pad_enc(input logic [2:0] mode, input logic io_out,
                                       input logic io_oeb);
    pad_cfg_t p;
    p = '{dm: DM_ANALOG, inp_dis: 1'b1, oeb: 1'b1, out: 1'b0};
    case (mode)
      MODE_INPUT:    p = '{dm: DM_INPUT,     inp_dis: 1'b0, oeb: 1'b1,   out: 1'b0};
      MODE_INPUT_PD: p = '{dm: DM_PULL_DOWN, inp_dis: 1'b0, oeb: 1'b0,   out: 1'b0};
      MODE_INPUT_PU: p = '{dm: DM_PULL_UP,   inp_dis: 1'b0, oeb: 1'b0,   out: 1'b1};
      MODE_OUTPUT:   p = '{dm: DM_STRONG,    inp_dis: 1'b1, oeb: 1'b0,   out: io_out};
      MODE_BIDIR:    p = '{dm: DM_STRONG,    inp_dis: 1'b0, oeb: io_oeb, out: io_out};
      default:       p = '{dm: DM_ANALOG,    inp_dis: 1'b1, oeb: 1'b1,   out: 1'b0};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cf_gpio_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous pad input.
module cf_gpio_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  // NOTE: clocked state uses <= so every flop samples its pre-edge neighbour;
  // blocking assignments here would collapse the chain into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/cf_gpio_bank.sv
// Runtime-configurable bank of Openframe GPIO pad controllers with glitch-free
// mode sequencing. Optional edge interrupt enabled by CF_GPIO_BANK_IRQ_EN.
module cf_gpio_bank
  import cf_gpio_pkg::*;
#(
  parameter int         NUM_PINS    = 8,
  parameter int         SYNC_STAGES = 2,
  parameter int         PARK_CYCLES = 2,
  parameter logic [2:0] RESET_MODE  = 3'd1,
  localparam int        IW          = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [IW-1:0]         cfg_idx,
  input  logic [2:0]            cfg_mode,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  output logic [3*NUM_PINS-1:0] mode_q,
  input  logic [NUM_PINS-1:0]   io_out,
  input  logic [NUM_PINS-1:0]   io_oeb,
  output logic [NUM_PINS-1:0]   io_in,
  input  logic [NUM_PINS-1:0]   gpio_in,
  output logic [3*NUM_PINS-1:0] gpio_dm,
  output logic [NUM_PINS-1:0]   gpio_inp_dis,
  output logic [NUM_PINS-1:0]   gpio_oeb,
  output logic [NUM_PINS-1:0]   gpio_out,
  output logic [NUM_PINS-1:0]   gpio_analog_en,
  output logic [NUM_PINS-1:0]   gpio_analog_sel,
  output logic [NUM_PINS-1:0]   gpio_analog_pol,
  output logic [NUM_PINS-1:0]   gpio_ib_mode_sel,
  output logic [NUM_PINS-1:0]   gpio_vtrip_sel,
  output logic [NUM_PINS-1:0]   gpio_slow_sel,
  output logic [NUM_PINS-1:0]   gpio_holdover,
  output logic                  irq,
  input  logic [NUM_PINS-1:0]   irq_clr
);

  localparam int CW = $clog2(PARK_CYCLES + 1);

  seq_state_t                 state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [2:0]                 tgt_q, tgt_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic [NUM_PINS-1:0][2:0]   modes_q, modes_d;
  pad_cfg_t [NUM_PINS-1:0]    pad_q, pad_d;
  logic [NUM_PINS-1:0]        sync_in;

  logic       idx_ok;
  logic [2:0] cur_mode;
  logic       wr_bad;
  logic       accept;

  // Index decode via compare loop keeps out-of-range indices away from the arrays.
  always_comb begin
    idx_ok   = 1'b0;
    cur_mode = MODE_ANALOG;
    for (int n = 0; n < NUM_PINS; n++) begin
      if (cfg_idx == IW'(n)) begin
        idx_ok   = 1'b1;
        cur_mode = modes_q[n];
      end
    end
  end

  assign cfg_ready = (state_q == SEQ_IDLE);
  assign wr_bad    = cfg_we && (!cfg_ready || !idx_ok || !mode_valid(cfg_mode));
  assign accept    = cfg_we && cfg_ready && idx_ok && mode_valid(cfg_mode) &&
                     (cfg_mode != cur_mode);

  // Park occupies PARK_CYCLES visible cycles: PARK_CYCLES-1 in PARK plus the APPLY cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    err_d   = wr_bad;
    case (state_q)
      SEQ_IDLE: begin
        if (accept) begin
          idx_d   = cfg_idx;
          tgt_d   = cfg_mode;
          cnt_d   = CW'(PARK_CYCLES - 1);
          state_d = (PARK_CYCLES > 1) ? SEQ_PARK : SEQ_APPLY;
        end
      end
      SEQ_PARK: begin
        if (cnt_q <= CW'(1)) begin
          state_d = SEQ_APPLY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SEQ_APPLY: state_d = SEQ_IDLE;
      default:   state_d = SEQ_IDLE;
    endcase
  end

  always_comb begin
    modes_d = modes_q;
    pad_d   = pad_q;
    for (int n = 0; n < NUM_PINS; n++) begin
      if ((state_q == SEQ_APPLY) && (idx_q == IW'(n))) begin
        modes_d[n] = tgt_q;
      end
      if ((accept && (cfg_idx == IW'(n))) || ((state_q == SEQ_PARK) && (idx_q == IW'(n)))) begin
        pad_d[n] = PAD_PARK;
      end else begin
        pad_d[n] = pad_enc(modes_d[n], io_out[n], io_oeb[n]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      idx_q   <= '0;
      tgt_q   <= RESET_MODE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      // NOTE: mode and pad arrays are plain flops, not RAM, and must come out of
      // reset in a defined pad state, so they are reset like any other register.
      for (int n = 0; n < NUM_PINS; n++) begin
        modes_q[n] <= RESET_MODE;
        pad_q[n]   <= pad_enc(RESET_MODE, 1'b0, 1'b0);
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      modes_q <= modes_d;
      pad_q   <= pad_d;
    end
  end

  assign cfg_err = err_q;
  assign mode_q  = modes_q;

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_sync
    cf_gpio_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (gpio_in[g]),
      .q_o (sync_in[g])
    );
  end

  always_comb begin
    gpio_dm      = '0;
    gpio_inp_dis = '0;
    gpio_oeb     = '0;
    gpio_out     = '0;
    io_in        = '0;
    for (int n = 0; n < NUM_PINS; n++) begin
      gpio_dm[3*n +: 3] = pad_q[n].dm;
      gpio_inp_dis[n]   = pad_q[n].inp_dis;
      gpio_oeb[n]       = pad_q[n].oeb;
      gpio_out[n]       = pad_q[n].out;
      io_in[n]          = sync_in[n] & mode_senses(modes_q[n]);
    end
  end

  assign gpio_analog_en   = '0;
  assign gpio_analog_sel  = '0;
  assign gpio_analog_pol  = '0;
  assign gpio_ib_mode_sel = '0;
  assign gpio_vtrip_sel   = '0;
  assign gpio_slow_sel    = '0;
  assign gpio_holdover    = '0;

`ifdef CF_GPIO_BANK_IRQ_EN
  logic [NUM_PINS-1:0] prev_q, pend_q, pend_d, edge_hit;
  logic                irq_q;

  // Edges are taken on the raw synchronised value so a mode change alone never fires.
  always_comb begin
    edge_hit = '0;
    for (int n = 0; n < NUM_PINS; n++) begin
      edge_hit[n] = (sync_in[n] ^ prev_q[n]) & mode_senses(modes_q[n]);
    end
    pend_d = (pend_q & ~irq_clr) | edge_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= sync_in;
      pend_q <= pend_d;
      irq_q  <= |pend_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = ^irq_clr;
  assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_cf_gpio_bank.sv
// Directed self-checking bench for cf_gpio_bank (6 pins, 2 sync stages, 2 park cycles).
module tb_cf_gpio_bank;

  localparam int NP = 6;
  localparam int IW = 3;
`ifdef CF_GPIO_BANK_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [IW-1:0]   cfg_idx;
  logic [2:0]      cfg_mode;
  logic            cfg_ready;
  logic            cfg_err;
  logic [3*NP-1:0] mode_q;
  logic [NP-1:0]   io_out, io_oeb, io_in, gpio_in;
  logic [3*NP-1:0] gpio_dm;
  logic [NP-1:0]   gpio_inp_dis, gpio_oeb, gpio_out;
  logic [NP-1:0]   gpio_analog_en, gpio_analog_sel, gpio_analog_pol, gpio_ib_mode_sel;
  logic [NP-1:0]   gpio_vtrip_sel, gpio_slow_sel, gpio_holdover;
  logic            irq;
  logic [NP-1:0]   irq_clr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3*NP-1:0] exp_modes;

  always #5 clk = ~clk;

  cf_gpio_bank #(
    .NUM_PINS    (NP),
    .SYNC_STAGES (2),
    .PARK_CYCLES (2),
    .RESET_MODE  (3'd1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_we           (cfg_we),
    .cfg_idx          (cfg_idx),
    .cfg_mode         (cfg_mode),
    .cfg_ready        (cfg_ready),
    .cfg_err          (cfg_err),
    .mode_q           (mode_q),
    .io_out           (io_out),
    .io_oeb           (io_oeb),
    .io_in            (io_in),
    .gpio_in          (gpio_in),
    .gpio_dm          (gpio_dm),
    .gpio_inp_dis     (gpio_inp_dis),
    .gpio_oeb         (gpio_oeb),
    .gpio_out         (gpio_out),
    .gpio_analog_en   (gpio_analog_en),
    .gpio_analog_sel  (gpio_analog_sel),
    .gpio_analog_pol  (gpio_analog_pol),
    .gpio_ib_mode_sel (gpio_ib_mode_sel),
    .gpio_vtrip_sel   (gpio_vtrip_sel),
    .gpio_slow_sel    (gpio_slow_sel),
    .gpio_holdover    (gpio_holdover),
    .irq              (irq),
    .irq_clr          (irq_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write(input int idx, input int mode);
    cfg_we   = 1'b1;
    cfg_idx  = IW'(idx);
    cfg_mode = 3'(mode);
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_mode = '0;
    io_out = '0; io_oeb = '0; gpio_in = '0; irq_clr = '0;
    exp_modes = {NP{3'd1}};
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_dm",      32'(gpio_dm), 32'({NP{3'b001}}));
    check("rst_oeb",     32'(gpio_oeb), 32'h3F);
    check("rst_inp_dis", 32'(gpio_inp_dis), 32'h0);
    check("rst_out",     32'(gpio_out), 32'h0);
    check("rst_ready",   32'(cfg_ready), 32'h1);
    check("rst_err",     32'(cfg_err), 32'h0);
    check("rst_io_in",   32'(io_in), 32'h0);
    check("rst_mode",    32'(mode_q), 32'(exp_modes));
    check("rst_irq",     32'(irq), 32'h0);
    check("tied_zero",   32'(gpio_analog_en | gpio_analog_sel | gpio_analog_pol |
                             gpio_ib_mode_sel | gpio_vtrip_sel | gpio_slow_sel |
                             gpio_holdover), 32'h0);

    // Synchroniser latency: two edges
    gpio_in = 6'b000001;
    tick();
    check("sync_1clk", 32'(io_in), 32'h0);
    tick();
    check("sync_2clk", 32'(io_in), 32'h1);

    // Pin3 -> OUTPUT with park window
    gpio_in = 6'b001001;
    io_out  = 6'b001000;
    write(3, 4);
    check("p3_park1_oeb", 32'(gpio_oeb[3]), 32'h1);
    check("p3_park1_dm",  32'(gpio_dm[9 +: 3]), 32'h1);
    check("p3_park1_rdy", 32'(cfg_ready), 32'h0);
    tick();
    check("p3_park2_oeb", 32'(gpio_oeb[3]), 32'h1);
    check("p3_park2_rdy", 32'(cfg_ready), 32'h0);
    tick();
    exp_modes[9 +: 3] = 3'd4;
    check("p3_dm",      32'(gpio_dm[9 +: 3]), 32'h6);
    check("p3_oeb",     32'(gpio_oeb[3]), 32'h0);
    check("p3_out",     32'(gpio_out[3]), 32'h1);
    check("p3_inp_dis", 32'(gpio_inp_dis[3]), 32'h1);
    check("p3_ready",   32'(cfg_ready), 32'h1);
    check("p3_mode",    32'(mode_q), 32'(exp_modes));
    check("p3_io_in",   32'(io_in), 32'h01);
    io_out = 6'b000000;
    tick();
    check("p3_out_follow", 32'(gpio_out[3]), 32'h0);

    // Rejected writes
    write(1, 6);
    check("bad_mode_err", 32'(cfg_err), 32'h1);
    check("bad_mode_rdy", 32'(cfg_ready), 32'h1);
    tick();
    check("bad_mode_pulse", 32'(cfg_err), 32'h0);
    check("bad_mode_keep",  32'(mode_q), 32'(exp_modes));
    write(6, 4);
    check("bad_idx_err", 32'(cfg_err), 32'h1);
    tick();
    check("bad_idx_pulse", 32'(cfg_err), 32'h0);
    check("bad_idx_keep",  32'(mode_q), 32'(exp_modes));

    // Write during PARK is dropped, sequence continues
    write(1, 2);
    check("busy_rdy", 32'(cfg_ready), 32'h0);
    write(2, 4);
    check("busy_err",      32'(cfg_err), 32'h1);
    check("busy_park_oeb", 32'(gpio_oeb[1]), 32'h1);
    tick();
    exp_modes[3 +: 3] = 3'd2;
    check("pd_dm",    32'(gpio_dm[3 +: 3]), 32'h3);
    check("pd_oeb",   32'(gpio_oeb[1]), 32'h0);
    check("pd_err",   32'(cfg_err), 32'h0);
    check("pd_ready", 32'(cfg_ready), 32'h1);
    check("pd_mode",  32'(mode_q), 32'(exp_modes));

    // Same-mode write is a silent no-op
    write(0, 1);
    check("same_rdy", 32'(cfg_ready), 32'h1);
    check("same_err", 32'(cfg_err), 32'h0);

    // BIDIR pin2
    io_out = 6'b000100;
    io_oeb = 6'b000000;
    write(2, 5);
    tick(); tick();
    exp_modes[6 +: 3] = 3'd5;
    check("bidir_dm",      32'(gpio_dm[6 +: 3]), 32'h6);
    check("bidir_oeb",     32'(gpio_oeb[2]), 32'h0);
    check("bidir_out",     32'(gpio_out[2]), 32'h1);
    check("bidir_inp_dis", 32'(gpio_inp_dis[2]), 32'h0);
    io_oeb = 6'b000100;
    tick();
    check("bidir_oeb_follow", 32'(gpio_oeb[2]), 32'h1);

    // INPUT_PU pin4
    write(4, 3);
    tick(); tick();
    exp_modes[12 +: 3] = 3'd3;
    check("pu_dm",  32'(gpio_dm[12 +: 3]), 32'h2);
    check("pu_oeb", 32'(gpio_oeb[4]), 32'h0);
    check("pu_out", 32'(gpio_out[4]), 32'h1);

    // ANALOG pin0 with gpio_in still high
    write(0, 0);
    tick(); tick();
    exp_modes[0 +: 3] = 3'd0;
    check("an_dm",      32'(gpio_dm[0 +: 3]), 32'h0);
    check("an_inp_dis", 32'(gpio_inp_dis[0]), 32'h1);
    check("an_io_in",   32'(io_in), 32'h0);
    check("an_mode",    32'(mode_q), 32'(exp_modes));

    // Reset in the middle of a park
    gpio_in = 6'b000000;
    io_oeb  = 6'b000000;
    write(5, 4);
    check("mid_rdy", 32'(cfg_ready), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_modes = {NP{3'd1}};
    check("mid_rst_dm",    32'(gpio_dm), 32'({NP{3'b001}}));
    check("mid_rst_oeb",   32'(gpio_oeb), 32'h3F);
    check("mid_rst_rdy",   32'(cfg_ready), 32'h1);
    check("mid_rst_err",   32'(cfg_err), 32'h0);
    check("mid_rst_mode",  32'(mode_q), 32'(exp_modes));
    tick();
    check("mid_rst_abort", 32'(mode_q), 32'(exp_modes));
    check("mid_rst_rdy2",  32'(cfg_ready), 32'h1);

    // Edge interrupt on INPUT pin1
    gpio_in = 6'b000010;
    tick(); tick();
    check("irq_pre", 32'(irq), 32'h0);
    tick();
    check("irq_rise", 32'(irq), 32'(IRQ_ON));
    irq_clr = 6'b000010;
    tick();
    irq_clr = 6'b000000;
    check("irq_clr", 32'(irq), 32'h0);
    gpio_in = 6'b000000;
    tick(); tick();
    irq_clr = 6'b000010;
    tick();
    irq_clr = 6'b000000;
    check("irq_clr_vs_edge", 32'(irq), 32'(IRQ_ON));
    irq_clr = 6'b000010;
    tick();
    irq_clr = 6'b000000;
    check("irq_final_clr", 32'(irq), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
